// File: rtl/usbf_pkt_tx.sv
// USB function packet transmitter: builds handshake and DATA packets (with CRC16)
// and drives the 8-bit UTMI transmit interface.
module usbf_pkt_tx #(
    parameter int unsigned MAX_PKT_SIZE = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        send_hs,
    input  logic [1:0]  hs_sel,
    input  logic        send_data,
    input  logic [1:0]  data_pid_sel,
    input  logic        send_zlp,
    input  logic [7:0]  tx_byte,
    input  logic        tx_byte_valid,
    input  logic        tx_byte_last,
    output logic        tx_byte_ack,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        tx_done,
    output logic        underrun_err,
    output logic        pkt_trunc,
    output logic [10:0] tx_byte_cnt
);

    localparam int unsigned CNT_W = 11;
    localparam int unsigned CRC_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PID,
        S_DATA,
        S_CRC1,
        S_CRC2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [7:0]         r_tx_data,  w_tx_data_nxt;
    logic               r_tx_valid, w_tx_valid_nxt;
    logic               r_busy,     w_busy_nxt;
    logic               r_done,     w_done_nxt;
    logic               r_under,    w_under_nxt;
    logic               r_trunc,    w_trunc_nxt;
    logic [CNT_W-1:0]   r_cnt,      w_cnt_nxt;
    logic [CRC_W-1:0]   r_crc,      w_crc_nxt;
    logic               r_is_hs,    w_is_hs_nxt;
    logic               r_zlp,      w_zlp_nxt;
    logic               r_last,     w_last_nxt;
    logic               w_ack;
    logic               w_accept;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_at_max;
    logic [CRC_W-1:0]   w_crc_upd;

    // Serial CRC16 (x^16+x^15+x^2+1), data bit 0 shifted in first
    function automatic logic [CRC_W-1:0] crc16_byte(input logic [CRC_W-1:0] c, input logic [7:0] d);
        logic [CRC_W-1:0] r;
        logic             fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb = r[15] ^ d[i];
            r  = {r[14:0], 1'b0};
            if (fb) r = r ^ 16'h8005;
        end
        return r;
    endfunction

    function automatic logic [7:0] crc_byte1(input logic [CRC_W-1:0] c);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[i] = ~c[15-i];
        return b;
    endfunction

    function automatic logic [7:0] crc_byte2(input logic [CRC_W-1:0] c);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[i] = ~c[7-i];
        return b;
    endfunction

    function automatic logic [7:0] pid_byte(input logic [3:0] p);
        return {~p, p};
    endfunction

    function automatic logic [3:0] hs_pid(input logic [1:0] sel);
        case (sel)
            2'd0:    return 4'h2;
            2'd1:    return 4'hA;
            2'd2:    return 4'hE;
            default: return 4'h6;
        endcase
    endfunction

    function automatic logic [3:0] data_pid(input logic [1:0] sel);
        case (sel)
            2'd0:    return 4'h3;
            2'd1:    return 4'hB;
            2'd2:    return 4'h7;
            default: return 4'hF;
        endcase
    endfunction

    assign w_accept  = r_tx_valid & tx_ready;
    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_at_max  = (w_cnt_inc == CNT_W'(MAX_PKT_SIZE));
    assign w_crc_upd = crc16_byte(r_crc, r_tx_data);

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_tx_data  <= 8'h00;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_under    <= 1'b0;
            r_trunc    <= 1'b0;
            r_cnt      <= '0;
            r_crc      <= 16'hFFFF;
            r_is_hs    <= 1'b0;
            r_zlp      <= 1'b0;
            r_last     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_tx_valid <= w_tx_valid_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_under    <= w_under_nxt;
            r_trunc    <= w_trunc_nxt;
            r_cnt      <= w_cnt_nxt;
            r_crc      <= w_crc_nxt;
            r_is_hs    <= w_is_hs_nxt;
            r_zlp      <= w_zlp_nxt;
            r_last     <= w_last_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (send_hs || send_data) w_state_nxt = S_PID;
            S_PID: begin
                if (w_accept) begin
                    if (r_is_hs)            w_state_nxt = S_IDLE;
                    else if (r_zlp)         w_state_nxt = S_CRC1;
                    else if (tx_byte_valid) w_state_nxt = S_DATA;
                    else                    w_state_nxt = S_IDLE;
                end
            end
            S_DATA: begin
                if (w_accept) begin
                    if (r_last || w_at_max) w_state_nxt = S_CRC1;
                    else if (tx_byte_valid) w_state_nxt = S_DATA;
                    else                    w_state_nxt = S_IDLE;
                end
            end
            S_CRC1: if (w_accept) w_state_nxt = S_CRC2;
            S_CRC2: if (w_accept) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output / datapath next values; a stalled PHY leaves everything holding
    always_comb begin
        w_tx_data_nxt  = r_tx_data;
        w_tx_valid_nxt = r_tx_valid;
        w_done_nxt     = 1'b0;
        w_under_nxt    = 1'b0;
        w_trunc_nxt    = 1'b0;
        w_cnt_nxt      = r_cnt;
        w_crc_nxt      = r_crc;
        w_is_hs_nxt    = r_is_hs;
        w_zlp_nxt      = r_zlp;
        w_last_nxt     = r_last;
        w_ack          = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (send_hs) begin
                    w_tx_valid_nxt = 1'b1;
                    w_tx_data_nxt  = pid_byte(hs_pid(hs_sel));
                    w_is_hs_nxt    = 1'b1;
                end else if (send_data) begin
                    w_tx_valid_nxt = 1'b1;
                    w_tx_data_nxt  = pid_byte(data_pid(data_pid_sel));
                    w_is_hs_nxt    = 1'b0;
                    w_zlp_nxt      = send_zlp;
                    w_cnt_nxt      = '0;
                    w_crc_nxt      = 16'hFFFF;
                end
            end
            S_PID: begin
                if (w_accept) begin
                    if (r_is_hs) begin
                        w_tx_valid_nxt = 1'b0;
                        w_done_nxt     = 1'b1;
                    end else if (r_zlp) begin
                        w_tx_data_nxt = crc_byte1(r_crc);
                    end else if (tx_byte_valid) begin
                        w_ack         = 1'b1;
                        w_tx_data_nxt = tx_byte;
                        w_last_nxt    = tx_byte_last;
                    end else begin
                        w_tx_valid_nxt = 1'b0;
                        w_under_nxt    = 1'b1;
                        w_done_nxt     = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (w_accept) begin
                    w_cnt_nxt = w_cnt_inc;
                    w_crc_nxt = w_crc_upd;
                    if (r_last || w_at_max) begin
                        w_tx_data_nxt = crc_byte1(w_crc_upd);
                        w_trunc_nxt   = ~r_last;
                    end else if (tx_byte_valid) begin
                        w_ack         = 1'b1;
                        w_tx_data_nxt = tx_byte;
                        w_last_nxt    = tx_byte_last;
                    end else begin
                        w_tx_valid_nxt = 1'b0;
                        w_under_nxt    = 1'b1;
                        w_done_nxt     = 1'b1;
                    end
                end
            end
            S_CRC1: if (w_accept) w_tx_data_nxt = crc_byte2(r_crc);
            S_CRC2: begin
                if (w_accept) begin
                    w_tx_valid_nxt = 1'b0;
                    w_done_nxt     = 1'b1;
                end
            end
            default: begin
                w_tx_valid_nxt = 1'b0;
            end
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    assign tx_byte_ack  = w_ack;
    assign tx_data      = r_tx_data;
    assign tx_valid     = r_tx_valid;
    assign busy         = r_busy;
    assign tx_done      = r_done;
    assign underrun_err = r_under;
    assign pkt_trunc    = r_trunc;
    assign tx_byte_cnt  = r_cnt;

endmodule

// File: doc/usbf_pkt_tx.md
Name: usbf_pkt_tx

Overview:
- USB function packet transmitter. It builds handshake packets (ACK/NACK/STALL/NYET) and DATA packets (DATA0/DATA1/DATA2/MDATA), appending a CRC16.
- It drives the 8-bit UTMI TX interface and sits between the protocol engine/memory fetch path and the PHY.
- It is the transmit-side counterpart of the packet decoder.

Parameters:
- MAX_PKT_SIZE, 1024: maximum data payload bytes per packet before forced truncation (1..2047).

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-low
- send_hs  input  1  request a handshake packet; sampled in IDLE only
- hs_sel  input  2  handshake type: 0=ACK, 1=NACK, 2=STALL, 3=NYET
- send_data  input  1  request a DATA packet; sampled in IDLE only
- data_pid_sel  input  2  0=DATA0, 1=DATA1, 2=DATA2, 3=MDATA
- send_zlp  input  1  with send_data: zero-length packet, no payload fetched
- tx_byte  input  8  payload byte from the store unit
- tx_byte_valid  input  1  tx_byte is valid
- tx_byte_last  input  1  tx_byte is the final payload byte
- tx_byte_ack  output  1  payload byte consumed this cycle
- tx_data  output  8  UTMI TxData
- tx_valid  output  1  UTMI TxValid
- tx_ready  input  1  UTMI TxReady
- busy  output  1  packet in progress
- tx_done  output  1  one-cycle pulse when a packet ends (normal or abort)
- underrun_err  output  1  one-cycle pulse when the payload source was empty when needed
- pkt_trunc  output  1  one-cycle pulse when MAX_PKT_SIZE was reached without last
- tx_byte_cnt  output  11  payload bytes accepted by the PHY in the current or last packet

Behaviour:
- Reset values: tx_valid=0, tx_data=8'h00, busy=0, all pulse outputs=0, tx_byte_cnt=0, state=IDLE. Reset mid-packet drops tx_valid immediately, asynchronously.
- PID byte = {~pid[3:0], pid[3:0]}:
  - ACK D2, NACK 5A, STALL 1E, NYET 96
  - DATA0 C3, DATA1 4B, DATA2 87, MDATA 0F
- States: IDLE, PID, DATA, CRC1, CRC2. tx_data and tx_valid are registered.
- A byte is "accepted" in any cycle where tx_valid & tx_ready.
- IDLE:
  - If send_hs: next cycle tx_valid=1, tx_data=HS PID, busy=1, state PID.
  - Else if send_data: same, with DATA PID; the zlp flag is latched and tx_byte_cnt is cleared.
  - If both requests are asserted, the handshake wins and the data request is dropped; the requester must re-request.
  - Requests asserted outside IDLE are ignored.
- PID, on acceptance:
  - Handshake: tx_valid=0, tx_done pulse, go to IDLE.
  - DATA with zlp: load CRC byte 1, go to CRC1.
  - Otherwise, if tx_byte_valid: tx_byte_ack=1, load tx_byte, capture the last flag, go to DATA.
  - Otherwise (source empty): underrun abort.
- tx_byte_ack is combinational: it is high only in the acceptance cycle when a new payload byte is loaded.
- DATA, on acceptance:
  - tx_byte_cnt increments.
  - If the captured last flag is set, or the incremented count == MAX_PKT_SIZE: load CRC byte 1, go to CRC1. pkt_trunc pulses in the second case when last was not set.
  - Otherwise: fetch the next byte as in PID; underrun abort if tx_byte_valid=0.
- Underrun abort: tx_valid=0 next cycle, underrun_err and tx_done pulse, go to IDLE. The PHY ends the packet without CRC and the host discards it.
- CRC16:
  - Register c initialised to FFFF when the DATA PID is loaded.
  - Updated with each payload byte when accepted by the PHY, bit 0 first, polynomial x^16+x^15+x^2+1.
  - CRC byte 1: bit i = ~c[15-i]. CRC byte 2: bit i = ~c[7-i].
- CRC1: on acceptance, present CRC byte 2 and go to CRC2.
- CRC2: on acceptance, tx_valid=0, tx_done pulse, busy=0 next cycle, go to IDLE.
- While tx_ready=0, tx_data and tx_valid hold steady; no stall limit is enforced.
- busy is high from the cycle after acceptance of a request until the cycle after tx_done.

Test Plan:
- ACK: send_hs=1, hs_sel=0 in IDLE, tx_ready=1 → tx_valid high for exactly 1 cycle with tx_data=D2; tx_done then pulses; no tx_byte_ack.
- Zero-length DATA1: send_data=1, data_pid_sel=1, send_zlp=1 → tx_data sequence 4B, 00, 00; tx_byte_cnt=0; tx_done once.
- DATA0 with payload 00 01 02 03 (last on 03) and random tx_ready stalls → PID C3, then the 4 bytes in order, then 2 CRC bytes.
  - Running the receiver CRC16 (init FFFF) over payload plus CRC leaves residual 800D.
  - tx_byte_cnt=4; tx_byte_ack pulses 4 times.
- Underrun: DATA0, tx_byte_valid drops after 2 bytes → underrun_err pulse, tx_valid low after the 2nd byte is accepted, no CRC bytes, tx_done, IDLE.
- Truncation: MAX_PKT_SIZE=8, continuous data with no last → exactly 8 payload bytes, pkt_trunc pulse, then valid CRC (residual 800D).
- Simultaneous send_hs and send_data → only the handshake is sent. Async reset asserted mid-DATA → tx_valid=0 at once; after release, busy=0 and a new ACK request is sent correctly.
